// File: rtl/tt_um_unload.sv
// Streams a snapshot of a ternary weight matrix as bit-plane words (MSB then LSB per column).
// Optional illegal-code (2'b10) detection is built only when UNLOAD_ILLEGAL_CHECK_EN is defined.
module tt_um_unload #(
  parameter int MaxInLen  = 16,
  parameter int MaxOutLen = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ena,
  input  logic [2*MaxInLen*MaxOutLen-1:0]  ui_weights,
  input  logic [6:0]                       ui_param,
  input  logic                             ui_ready,
  output logic [MaxInLen-1:0]              uo_data,
  output logic                             uo_valid,
  output logic                             uo_busy,
  output logic                             uo_done,
  output logic                             uo_err
);

  localparam int ColW = (MaxOutLen > 1) ? $clog2(MaxOutLen) : 1;

  typedef enum logic [1:0] {IDLE, MSB, LSB, DONE} state_t;

  state_t              state_q, state_d;
  logic [ColW-1:0]     col_q, col_d;
  logic [ColW-1:0]     last_q, last_d;
  logic                ena_q;
  logic                hold_q;
  logic                start;
  int                  lim;
  logic [MaxInLen-1:0] word;

  logic [MaxInLen-1:0] msb_w [MaxOutLen];
  logic [MaxInLen-1:0] lsb_w [MaxOutLen];
  logic [MaxInLen-1:0] msb_q [MaxOutLen];
  logic [MaxInLen-1:0] lsb_q [MaxOutLen];

  logic unused_param;
  assign unused_param = ^ui_param[6:3];

  // Regroup the flat weight bus into per-column bit planes.
  genvar gi, gc;
  generate
    for (gc = 0; gc < MaxOutLen; gc++) begin : g_col
      for (gi = 0; gi < MaxInLen; gi++) begin : g_row
        assign msb_w[gc][gi] = ui_weights[2*(gi*MaxOutLen+gc)+1];
        assign lsb_w[gc][gi] = ui_weights[2*(gi*MaxOutLen+gc)];
      end
    end
  endgenerate

  always_comb begin
    lim = int'(ui_param[2:0]);
    if (lim > MaxOutLen - 1) lim = MaxOutLen - 1;
  end

  // hold_q remembers that ena was high through reset, so a fresh rising edge is needed.
  assign start = (state_q == IDLE) && ena && !ena_q && !hold_q;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = MSB;
          col_d   = '0;
          last_d  = lim[ColW-1:0];
        end
      end
      MSB: begin
        if (!ena)          state_d = IDLE;
        else if (ui_ready) state_d = LSB;
      end
      LSB: begin
        if (!ena) begin
          state_d = IDLE;
        end else if (ui_ready) begin
          if (col_q == last_q) begin
            state_d = DONE;
          end else begin
            col_d   = col_q + 1'b1;
            state_d = MSB;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      last_q  <= '0;
      ena_q   <= 1'b0;
      hold_q  <= ena;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      last_q  <= last_d;
      ena_q   <= ena;
      hold_q  <= hold_q && ena;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && start) begin
      msb_q <= msb_w;
      lsb_q <= lsb_w;
    end
  end

  assign word     = (state_q == MSB) ? msb_q[col_q] : lsb_q[col_q];
  assign uo_valid = !rst && ((state_q == MSB) || (state_q == LSB));
  assign uo_data  = uo_valid ? word : '0;
  assign uo_busy  = !rst && (state_q != IDLE);
  assign uo_done  = !rst && (state_q == DONE);

`ifdef UNLOAD_ILLEGAL_CHECK_EN
  logic illegal;
  logic err_q;

  // Only columns that will actually be sent are inspected.
  always_comb begin
    illegal = 1'b0;
    for (int c = 0; c < MaxOutLen; c++) begin
      for (int i = 0; i < MaxInLen; i++) begin
        if ((c <= lim) && msb_w[c][i] && !lsb_w[c][i]) illegal = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)        err_q <= 1'b0;
    else if (start) err_q <= illegal;
  end

  assign uo_err = !rst && err_q;
`else
  assign uo_err = 1'b0;
`endif

endmodule

// File: tb/tb_tt_um_unload.sv
// Directed bench for tt_um_unload: queue-based transfer model checked every cycle plus literal spot checks.
module tb_tt_um_unload;
  localparam int IN  = 16;
  localparam int OUT = 8;
  localparam int WW  = 2*IN*OUT;
`ifdef UNLOAD_ILLEGAL_CHECK_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ena = 1'b0;
  logic [WW-1:0] ui_weights = '0;
  logic [6:0]    ui_param = '0;
  logic          ui_ready = 1'b0;
  logic [IN-1:0] uo_data;
  logic          uo_valid, uo_busy, uo_done, uo_err;

  int total = 0;
  int bad   = 0;

  tt_um_unload #(.MaxInLen(IN), .MaxOutLen(OUT)) dut (
    .clk(clk), .rst(rst), .ena(ena), .ui_weights(ui_weights), .ui_param(ui_param),
    .ui_ready(ui_ready), .uo_data(uo_data), .uo_valid(uo_valid), .uo_busy(uo_busy),
    .uo_done(uo_done), .uo_err(uo_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Bit b of every row's code in column c, as one word.
  function automatic logic [IN-1:0] plane(input logic [WW-1:0] w, input int c, input int b);
    logic [IN-1:0] r;
    logic [1:0]    code;
    r = '0;
    for (int i = 0; i < IN; i++) begin
      code = w[2*(i*OUT+c) +: 2];
      r[i] = code[b];
    end
    return r;
  endfunction

  // Model: a transfer is a queue of words still to be sent; phase 0 idle, 1 sending, 2 done.
  logic [IN-1:0] m_words[$];
  int            m_phase = 0;
  logic          m_prev  = 1'b0;
  logic          m_err   = 1'b0;
  int            m_last;
  logic [1:0]    m_code;

  always @(posedge clk) begin
    if (rst) begin
      m_words.delete();
      m_phase = 0;
      m_err   = 1'b0;
    end else begin
      case (m_phase)
        0: if (ena && !m_prev) begin
          m_last = (ui_param[2:0] > OUT-1) ? OUT-1 : int'(ui_param[2:0]);
          m_words.delete();
          m_err = 1'b0;
          for (int c = 0; c <= m_last; c++) begin
            m_words.push_back(plane(ui_weights, c, 1));
            m_words.push_back(plane(ui_weights, c, 0));
            for (int i = 0; i < IN; i++) begin
              m_code = ui_weights[2*(i*OUT+c) +: 2];
              if (ErrEn && m_code == 2'b10) m_err = 1'b1;
            end
          end
          m_phase = 1;
        end
        1: if (!ena) begin
          m_words.delete();
          m_phase = 0;
        end else if (ui_ready) begin
          void'(m_words.pop_front());
          if (m_words.size() == 0) m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
    m_prev = ena;
  end

  always @(negedge clk) begin
    logic          e_valid;
    logic [IN-1:0] e_data;
    e_valid = !rst && (m_phase == 1);
    e_data  = (e_valid && m_words.size() > 0) ? m_words[0] : '0;
    chk("m_valid", 32'(uo_valid), 32'(e_valid));
    chk("m_data",  32'(uo_data),  32'(e_data));
    chk("m_busy",  32'(uo_busy),  32'(!rst && m_phase != 0));
    chk("m_done",  32'(uo_done),  32'(!rst && m_phase == 2));
    chk("m_err",   32'(uo_err),   32'(!rst && m_err));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer;
    ena = 1'b0;
    tick();
    ena = 1'b1;
    tick();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_data"},  32'(uo_data),  32'h0);
    chk({nm, "_valid"}, 32'(uo_valid), 32'h0);
    chk({nm, "_busy"},  32'(uo_busy),  32'h0);
    chk({nm, "_done"},  32'(uo_done),  32'h0);
    chk({nm, "_err"},   32'(uo_err),   32'h0);
  endtask

  logic [WW-1:0] pat;

  initial begin
    for (int i = 0; i < IN; i++)
      for (int c = 0; c < OUT; c++)
        pat[2*(i*OUT+c) +: 2] = 2'((i + c) % 4);

    repeat (3) tick();
    chk_zero("rst_hold");
    rst = 1'b0;
    tick();
    chk_zero("post_rst");

    // All weights +1, two columns, ready always high.
    ui_weights = {128{2'b01}};
    ui_param   = 7'd1;
    ui_ready   = 1'b1;
    start_xfer();
    chk("cols_w0", 32'(uo_data), 32'h0000);
    chk("cols_v0", 32'(uo_valid), 32'h1);
    tick(); chk("cols_w1", 32'(uo_data), 32'hFFFF);
    tick(); chk("cols_w2", 32'(uo_data), 32'h0000);
    tick(); chk("cols_w3", 32'(uo_data), 32'hFFFF);
    tick(); chk("cols_done", 32'(uo_done), 32'h1);
    chk("cols_done_v", 32'(uo_valid), 32'h0);
    tick(); chk("cols_idle_busy", 32'(uo_busy), 32'h0);
    chk("cols_idle_done", 32'(uo_done), 32'h0);

    // Backpressure with a single -1 weight at row 3, column 0.
    ui_weights = '0;
    ui_weights[49:48] = 2'b11;
    ui_param   = 7'd0;
    ui_ready   = 1'b0;
    start_xfer();
    for (int k = 0; k < 3; k++) begin
      chk("bp_hold", 32'(uo_data), 32'h0008);
      chk("bp_hold_v", 32'(uo_valid), 32'h1);
      tick();
    end
    ui_weights = pat;
    ui_param   = 7'd7;
    chk("bp_snap", 32'(uo_data), 32'h0008);
    ui_ready = 1'b1;
    tick(); chk("bp_lsb", 32'(uo_data), 32'h0008);
    tick(); chk("bp_done", 32'(uo_done), 32'h1);
    tick();

    // Abort after five accepted words, then restart from MSB0.
    ui_weights = pat;
    ui_param   = 7'd7;
    start_xfer();
    repeat (5) tick();
    ena = 1'b0;
    tick();
    chk("abort_valid", 32'(uo_valid), 32'h0);
    chk("abort_busy",  32'(uo_busy),  32'h0);
    chk("abort_done",  32'(uo_done),  32'h0);
    ena = 1'b1;
    tick();
    chk("restart_v",   32'(uo_valid), 32'h1);
    chk("restart_msb0", 32'(uo_data), 32'hCCCC);
    tick(); chk("restart_lsb0", 32'(uo_data), 32'hAAAA);
    repeat (15) tick();
    chk("restart_done", 32'(uo_done), 32'h1);
    tick();

    // Reset in the LSB word of column 2, ena held high afterwards.
    ui_param = 7'd3;
    start_xfer();
    repeat (5) tick();
    chk("rmid_lsb2", 32'(uo_data), 32'hAAAA);
    rst = 1'b1;
    #1 chk_zero("rmid_during");
    tick();
    chk_zero("rmid_after");
    rst = 1'b0;
    repeat (3) begin
      tick();
      chk("rmid_no_start", 32'(uo_busy), 32'h0);
    end
    start_xfer();
    chk("rmid_fresh", 32'(uo_data), 32'hCCCC);
    repeat (8) tick();
    chk("rmid_done", 32'(uo_done), 32'h1);
    tick();

    // Illegal code at row 0, column 1.
    ui_weights = '0;
    ui_weights[3:2] = 2'b10;
    ui_param = 7'd1;
    start_xfer();
    chk("err_col1", 32'(uo_err), 32'(ErrEn));
    chk("err_msb0", 32'(uo_data), 32'h0000);
    tick(); tick();
    chk("err_msb1", 32'(uo_data), 32'h0001);
    tick(); tick();
    chk("err_sticky", 32'(uo_err), 32'(ErrEn));
    tick();
    ui_param = 7'd0;
    start_xfer();
    chk("err_col0_only", 32'(uo_err), 32'h0);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
